// File: rtl/hsv_tier1_seq.sv
// Sequencer for the Tier-1 HSV datapath: steps one RGB pixel through load, three compares,
// the subtract and the select, then holds the results on the bus until the consumer takes them.
module hsv_tier1_seq #(
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [14:0]      control_Tier1,
  output logic             busy,
  output logic [CNT_W-1:0] pix_count
);

  localparam logic [3:0] LastStep = 4'(STEP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCmpRg,
    StCmpMax,
    StCmpMin,
    StDelta,
    StSelect,
    StOut
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_step;

  assign last_step = (step_q == LastStep);

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= StIdle;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = '0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StLoad;
      StLoad: state_d = StCmpRg;
      StCmpRg, StCmpMax, StCmpMin, StDelta, StSelect: begin
        if (last_step) begin
          unique case (state_q)
            StCmpRg:  state_d = StCmpMax;
            StCmpMax: state_d = StCmpMin;
            StCmpMin: state_d = StDelta;
            StDelta:  state_d = StSelect;
            default:  state_d = StOut;
          endcase
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
          if (!abort) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort cancels the pixel from any busy state and suppresses the count.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      step_d  = '0;
    end
  end

  always_comb begin
    control_Tier1 = 15'h0000;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      StLoad:   control_Tier1 = 15'h0001;
      StCmpRg:  control_Tier1 = last_step ? 15'h0006 : 15'h0000;
      StCmpMax: control_Tier1 = last_step ? 15'h00A8 : 15'h00A0;
      StCmpMin: control_Tier1 = last_step ? 15'h02C4 : 15'h02C0;
      StDelta:  control_Tier1 = last_step ? 15'h0102 : 15'h0100;
      StSelect: control_Tier1 = last_step ? 15'h0010 : 15'h0000;
      StOut: begin
        control_Tier1 = 15'h7C00;
        out_valid     = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign pix_count = cnt_q;

endmodule

// File: tb/tb_hsv_tier1_seq.sv
// Bench for hsv_tier1_seq: two instances (1-cycle steps with a 2-bit counter, 3-cycle steps
// with a 16-bit counter) are exercised in turn against a per-pixel cycle-table model.
module tb_hsv_tier1_seq;

  logic        Clk;
  logic        reset     [2];
  logic        in_valid  [2];
  logic        abort     [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        busy      [2];
  logic [14:0] ctrl      [2];
  logic [1:0]  pc_a;
  logic [15:0] pc_b;

  int steps [2] = '{1, 3};
  int cw    [2] = '{2, 16};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit busy_m [2];
  int pos_m  [2];
  int cnt_m  [2];
  int acc_q  [$];

  hsv_tier1_seq #(.STEP_CYCLES(1), .CNT_W(2)) dut_a (
    .Clk          (Clk),
    .reset        (reset[0]),
    .in_valid     (in_valid[0]),
    .in_ready     (in_ready[0]),
    .abort        (abort[0]),
    .out_valid    (out_valid[0]),
    .out_ready    (out_ready[0]),
    .control_Tier1(ctrl[0]),
    .busy         (busy[0]),
    .pix_count    (pc_a)
  );

  hsv_tier1_seq #(.STEP_CYCLES(3), .CNT_W(16)) dut_b (
    .Clk          (Clk),
    .reset        (reset[1]),
    .in_valid     (in_valid[1]),
    .in_ready     (in_ready[1]),
    .abort        (abort[1]),
    .out_valid    (out_valid[1]),
    .out_ready    (out_ready[1]),
    .control_Tier1(ctrl[1]),
    .busy         (busy[1]),
    .pix_count    (pc_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] pc_of(input int s);
    return (s == 0) ? {14'd0, pc_a} : pc_b;
  endfunction

  // Expected control word at cycle offset pos of a pixel (0 = load cycle).
  function automatic logic [14:0] exp_ctrl(input int s, input int pos);
    logic [14:0] fin [5];
    logic [14:0] mid [5];
    int k;
    fin = '{15'h0006, 15'h00A8, 15'h02C4, 15'h0102, 15'h0010};
    mid = '{15'h0000, 15'h00A0, 15'h02C0, 15'h0100, 15'h0000};
    if (pos == 0) return 15'h0001;
    k = (pos - 1) / s;
    return (((pos - 1) % s) == s - 1) ? fin[k] : mid[k];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Compare outputs mid-cycle, then advance the model with the inputs seen at the edge.
  task automatic cycle(input int s);
    int L;
    logic [14:0] ec;
    logic eir, eov, eb;
    L = 1 + 5 * steps[s];
    @(negedge Clk);
    if (!busy_m[s]) begin
      ec = 15'h0000; eir = 1'b1; eov = 1'b0; eb = 1'b0;
    end else if (pos_m[s] < L) begin
      ec = exp_ctrl(steps[s], pos_m[s]); eir = 1'b0; eov = 1'b0; eb = 1'b1;
    end else begin
      ec = 15'h7C00; eir = 1'b0; eov = 1'b1; eb = 1'b1;
    end
    chk("control", {1'b0, ctrl[s]}, {1'b0, ec});
    chk("in_ready", {15'd0, in_ready[s]}, {15'd0, eir});
    chk("out_valid", {15'd0, out_valid[s]}, {15'd0, eov});
    chk("busy", {15'd0, busy[s]}, {15'd0, eb});
    chk("pix_count", pc_of(s), 16'(cnt_m[s]));
    @(posedge Clk);
    if (reset[s]) begin
      busy_m[s] = 1'b0;
      cnt_m[s]  = 0;
    end else if (!busy_m[s]) begin
      if (in_valid[s]) begin
        busy_m[s] = 1'b1;
        pos_m[s]  = 0;
        acc_q.push_back(cyc);
      end
    end else if (abort[s]) begin
      busy_m[s] = 1'b0;
    end else if (pos_m[s] < L) begin
      pos_m[s]++;
    end else if (out_ready[s]) begin
      busy_m[s] = 1'b0;
      cnt_m[s]  = (cnt_m[s] + 1) % (1 << cw[s]);
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int s);
    reset[s] = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    reset[s]  = 1'b0;
    busy_m[s] = 1'b0;
    pos_m[s]  = 0;
    cnt_m[s]  = 0;
  endtask

  task automatic wait_out(input int s, output int n);
    n = 1;
    while (out_valid[s] !== 1'b1 && n < 80) begin
      cycle(s);
      n++;
    end
  endtask

  initial begin
    int n;
    int S;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; in_valid[i] = 1'b0; abort[i] = 1'b0; out_ready[i] = 1'b0;
      busy_m[i] = 1'b0; pos_m[i] = 0; cnt_m[i] = 0;
    end

    for (int s = 0; s < 2; s++) begin
      S = steps[s];
      do_reset(s);
      repeat (5) cycle(s);

      // Single pixel, consumer ready.
      out_ready[s] = 1'b1;
      in_valid[s]  = 1'b1;
      cycle(s);
      in_valid[s] = 1'b0;
      wait_out(s, n);
      chk("latency", 16'(n), 16'(2 + 5 * S));
      cycle(s);
      chk("count_after_one", pc_of(s), 16'd1);

      // Consumer stalls for 10 cycles.
      out_ready[s] = 1'b0;
      in_valid[s]  = 1'b1;
      cycle(s);
      in_valid[s] = 1'b0;
      wait_out(s, n);
      repeat (10) cycle(s);
      chk("count_during_stall", pc_of(s), 16'd1);
      out_ready[s] = 1'b1;
      cycle(s);
      chk("count_after_stall", pc_of(s), 16'd2);

      // Abort in CMP_MAX.
      in_valid[s] = 1'b1;
      cycle(s);
      in_valid[s] = 1'b0;
      n = 0;
      while (pos_m[s] != S + 1 && n < 40) begin
        cycle(s);
        n++;
      end
      abort[s] = 1'b1;
      cycle(s);
      abort[s] = 1'b0;
      chk("abort_max_ctrl", {1'b0, ctrl[s]}, 16'h0000);
      chk("abort_max_busy", {15'd0, busy[s]}, 16'd0);
      cycle(s);

      // Abort together with out_ready in OUT.
      in_valid[s] = 1'b1;
      cycle(s);
      in_valid[s] = 1'b0;
      wait_out(s, n);
      abort[s] = 1'b1;
      cycle(s);
      abort[s] = 1'b0;
      chk("abort_out_count", pc_of(s), 16'd2);
      chk("abort_out_ctrl", {1'b0, ctrl[s]}, 16'h0000);
      cycle(s);

      // Four back-to-back pixels from a fresh count.
      do_reset(s);
      acc_q.delete();
      in_valid[s] = 1'b1;
      n = 0;
      while (acc_q.size() < 4 && n < 200) begin
        cycle(s);
        n++;
      end
      in_valid[s] = 1'b0;
      repeat (3 + 5 * S) cycle(s);
      chk("b2b_accepts", 16'(acc_q.size()), 16'd4);
      for (int k = 1; k < acc_q.size(); k++)
        chk("b2b_spacing", 16'(acc_q[k] - acc_q[k-1]), 16'(3 + 5 * S));
      chk("b2b_count", pc_of(s), 16'(4 % (1 << cw[s])));

      // Randomised traffic.
      repeat (400) begin
        in_valid[s]  = 1'($urandom_range(0, 1));
        out_ready[s] = ($urandom_range(0, 2) != 0);
        abort[s]     = ($urandom_range(0, 19) == 0);
        reset[s]     = ($urandom_range(0, 99) == 0);
        cycle(s);
      end
      reset[s] = 1'b1; in_valid[s] = 1'b0; abort[s] = 1'b0; out_ready[s] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
